if_fetch: RTL and testbench

Instruction-fetch (IF) stage of the 5-stage MIPS pipeline. It is the producer side of the IF→ID bus and the consumer side of the ID→IF branch bus. It owns the PC register and drives the instruction SRAM address. Each PC is issued one cycle ahead, so the instruction word arrives at the decode stage in the same cycle as its `{ce, pc}` pair. It honours `stall[0]` and keeps any branch redirect that is raised while IF is stalled.

---
 rtl/if_fetch.sv | 120 ++++++++++++
 tb/tb_if_fetch.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, addresses instruction SRAM and feeds {ce, pc} to ID.
// Optional misaligned-fetch detection is compiled in with `define IF_ADDR_CHECK_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [32:0] br_bus,
  output logic [32:0] if_to_id_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  output logic        fetch_adel
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc_reg;
  logic        ce_reg;
  logic        pend_v;
  logic [31:0] pend_addr;
  logic        adel_reg;

  logic        br_e;
  logic [31:0] br_addr;
  logic        hold;
  logic [31:0] next_pc;
  logic        next_bad;

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];
  assign hold    = stall[0];

  // Live branch beats a redirect captured during a stall; otherwise sequential.
  always_comb begin
    next_pc = pc_reg + 32'd4;
    if (br_e)        next_pc = br_addr;
    else if (pend_v) next_pc = pend_addr;
  end

`ifdef IF_ADDR_CHECK_EN
  assign next_bad = (next_pc[1:0] != 2'b00);
`else
  assign next_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_BOOT;
      pc_reg    <= RESET_PC;
      ce_reg    <= 1'b0;
      pend_v    <= 1'b0;
      pend_addr <= 32'd0;
      adel_reg  <= 1'b0;
    end else if (hold) begin
      // Latest redirect raised during a stall wins; PC and ce freeze.
      if (br_e) begin
        pend_v    <= 1'b1;
        pend_addr <= br_addr;
      end
    end else begin
      case (state)
        S_BOOT, S_RUN: begin
          pc_reg <= next_pc;
          pend_v <= 1'b0;
          if (next_bad) begin
            ce_reg   <= 1'b0;
            adel_reg <= 1'b1;
            state    <= S_FAULT;
          end else begin
            ce_reg   <= 1'b1;
            adel_reg <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_FAULT: begin
          // Only a fresh branch (typically the exception vector) clears the fault.
          if (br_e) begin
            pc_reg <= br_addr;
            pend_v <= 1'b0;
            if (next_bad) begin
              ce_reg   <= 1'b0;
              adel_reg <= 1'b1;
            end else begin
              ce_reg   <= 1'b1;
              adel_reg <= 1'b0;
              state    <= S_RUN;
            end
          end
        end
        default: begin
          state  <= S_BOOT;
          ce_reg <= 1'b0;
        end
      endcase
    end
  end

  assign inst_sram_en    = ce_reg;
  assign inst_sram_addr  = pc_reg;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'd0;
  assign if_to_id_bus    = {ce_reg, pc_reg};

`ifdef IF_ADDR_CHECK_EN
  assign fetch_adel = adel_reg;
  logic unused_ok;
  assign unused_ok = &{1'b0, stall[5:1]};
`else
  assign fetch_adel = 1'b0;
  logic unused_ok;
  assign unused_ok = &{1'b0, stall[5:1], adel_reg};
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: reset, sequential fetch, branch, stall/pending redirect, wrap, misalignment.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        fetch_adel;

  int compared = 0;
  int mismatched = 0;

  if_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .br_bus(br_bus),
    .if_to_id_bus(if_to_id_bus), .inst_sram_en(inst_sram_en),
    .inst_sram_wen(inst_sram_wen), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata), .fetch_adel(fetch_adel)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [32:0] act, input logic [32:0] exp);
    compared++;
    assert (act === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  // Full check of fetch outputs for one cycle.
  task automatic expect_fetch(input string tag, input logic ce, input logic [31:0] pc,
                              input logic adel);
    chk({tag, ".bus"}, if_to_id_bus, {ce, pc});
    chk({tag, ".addr"}, {1'b0, inst_sram_addr}, {1'b0, pc});
    chk({tag, ".en"}, {32'd0, inst_sram_en}, {32'd0, ce});
    chk({tag, ".adel"}, {32'd0, fetch_adel}, {32'd0, adel});
  endtask

  initial begin
    rst = 1'b1; stall = 6'd0; br_bus = 33'd0;

    // Reset held three cycles
    step(); step(); step();
    expect_fetch("reset", 1'b0, 32'hBFBF_FFFC, 1'b0);
    chk("reset.wen_wdata", {1'b0, inst_sram_wdata}, 33'd0);
    chk("reset.wen", {29'd0, inst_sram_wen}, 33'd0);

    rst = 1'b0;
    step(); expect_fetch("boot0", 1'b1, 32'hBFC0_0000, 1'b0);
    step(); expect_fetch("boot1", 1'b1, 32'hBFC0_0004, 1'b0);
    step(); expect_fetch("boot2", 1'b1, 32'hBFC0_0008, 1'b0);

    // Live branch
    br_bus = {1'b1, 32'hBFC0_0100};
    step(); expect_fetch("br_live", 1'b1, 32'hBFC0_0100, 1'b0);
    br_bus = 33'd0;
    step(); expect_fetch("br_seq", 1'b1, 32'hBFC0_0104, 1'b0);

    // Steer to 0xBFC0_0010 for the stall test
    br_bus = {1'b1, 32'hBFC0_000C};
    step(); expect_fetch("to_0c", 1'b1, 32'hBFC0_000C, 1'b0);
    br_bus = 33'd0;
    step(); expect_fetch("to_10", 1'b1, 32'hBFC0_0010, 1'b0);

    stall = 6'b000001;
    step(); expect_fetch("stall1", 1'b1, 32'hBFC0_0010, 1'b0);
    step(); expect_fetch("stall2", 1'b1, 32'hBFC0_0010, 1'b0);
    step(); expect_fetch("stall3", 1'b1, 32'hBFC0_0010, 1'b0);
    stall = 6'd0;
    step(); expect_fetch("stall_rel", 1'b1, 32'hBFC0_0014, 1'b0);

    // Upper stall bits are ignored
    stall = 6'b111110;
    step(); expect_fetch("stall_hi", 1'b1, 32'hBFC0_0018, 1'b0);
    stall = 6'd0;
    // Redirect back to 0xBFC0_0014 for the pending test
    br_bus = {1'b1, 32'hBFC0_0014};
    step(); br_bus = 33'd0;

    // Pending redirect: latest pulse during stall wins
    stall = 6'b000001;
    br_bus = {1'b1, 32'h8000_1000};
    step(); expect_fetch("pend_a", 1'b1, 32'hBFC0_0014, 1'b0);
    br_bus = 33'd0;
    step();
    br_bus = {1'b1, 32'h8000_2000};
    step(); expect_fetch("pend_b", 1'b1, 32'hBFC0_0014, 1'b0);
    br_bus = 33'd0; stall = 6'd0;
    step(); expect_fetch("pend_rel", 1'b1, 32'h8000_2000, 1'b0);
    step(); expect_fetch("pend_seq", 1'b1, 32'h8000_2004, 1'b0);

    // Live branch at release beats the pending one
    stall = 6'b000001;
    br_bus = {1'b1, 32'h8000_1000};
    step(); br_bus = 33'd0;
    step();
    stall = 6'd0; br_bus = {1'b1, 32'h8000_3000};
    step(); expect_fetch("live_wins", 1'b1, 32'h8000_3000, 1'b0);
    br_bus = 33'd0;
    step(); expect_fetch("pend_cleared", 1'b1, 32'h8000_3004, 1'b0);

    // Wrap
    br_bus = {1'b1, 32'hFFFF_FFFC};
    step(); expect_fetch("wrap_a", 1'b1, 32'hFFFF_FFFC, 1'b0);
    br_bus = 33'd0;
    step(); expect_fetch("wrap_b", 1'b1, 32'h0000_0000, 1'b0);

    // Reset with a pending redirect, then stall during boot
    stall = 6'b000001;
    br_bus = {1'b1, 32'h8000_4000};
    step(); br_bus = 33'd0;
    rst = 1'b1;
    step(); expect_fetch("rst_mid", 1'b0, 32'hBFBF_FFFC, 1'b0);
    rst = 1'b0;
    step(); expect_fetch("boot_stall", 1'b0, 32'hBFBF_FFFC, 1'b0);
    stall = 6'd0;
    step(); expect_fetch("reboot0", 1'b1, 32'hBFC0_0000, 1'b0);
    step(); expect_fetch("reboot1", 1'b1, 32'hBFC0_0004, 1'b0);

    // Misaligned redirect
    br_bus = {1'b1, 32'hBFC0_0102};
`ifdef IF_ADDR_CHECK_EN
    step(); expect_fetch("adel_a", 1'b0, 32'hBFC0_0102, 1'b1);
    br_bus = 33'd0;
    step(); expect_fetch("adel_hold", 1'b0, 32'hBFC0_0102, 1'b1);
    br_bus = {1'b1, 32'hBFC0_0200};
    step(); expect_fetch("adel_exit", 1'b1, 32'hBFC0_0200, 1'b0);
    br_bus = 33'd0;
    step(); expect_fetch("adel_seq", 1'b1, 32'hBFC0_0204, 1'b0);
`else
    step(); expect_fetch("mis_a", 1'b1, 32'hBFC0_0102, 1'b0);
    br_bus = 33'd0;
    step(); expect_fetch("mis_b", 1'b1, 32'hBFC0_0106, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
